// File: rtl/mole_whack_judge.sv
// Mole-whack judge: accepts per-lane spawns, times each mole's window,
// and scores debounced whacks as hits or misses.
module mole_whack_judge #(
  parameter int NUM_MOLES      = 4,
  parameter int MAX_MS         = 2047,
  parameter int BASE_WINDOW_MS = 1600,
  parameter int SCORE_MAX      = 9999,
  parameter int MISS_LIMIT     = 3,
  localparam int SW = $clog2(SCORE_MAX + 1),
  localparam int MW = $clog2(MISS_LIMIT + 1)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 ms_tick,
  input  logic                 game_start,
  input  logic [1:0]           level,
  input  logic [NUM_MOLES-1:0] spawn,
  input  logic [NUM_MOLES-1:0] whack,
  output logic [NUM_MOLES-1:0] spawn_ack,
  output logic [NUM_MOLES-1:0] mole_up,
  output logic                 hit_pulse,
  output logic                 miss_pulse,
  output logic [SW-1:0]        score,
  output logic [MW-1:0]        misses,
  output logic                 game_over
);

  localparam int CW  = $clog2(MAX_MS + 1);
  localparam int SWS = SW + 4;
  localparam int MWS = MW + 4;
  localparam logic [CW-1:0] BASE_W = CW'(BASE_WINDOW_MS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_OVER
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_MOLES-1:0] up_q, up_d;
  logic [NUM_MOLES-1:0] ack_q, ack_d;
  logic [CW-1:0]        cnt_q [NUM_MOLES];
  logic [CW-1:0]        cnt_d [NUM_MOLES];
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;
  logic [SW-1:0]        score_q, score_d;
  logic [MW-1:0]        misses_q, misses_d;

  logic [NUM_MOLES-1:0] hit_ev, miss_ev;
  logic [CW-1:0]        win;
  logic [3:0]           nh, nm;
  logic [SWS-1:0]       ssum;
  logic [MWS-1:0]       msum;

  // Lane timing, hit/miss judging, scoring and game FSM next-state.
  always_comb begin
    state_d  = state_q;
    up_d     = up_q;
    cnt_d    = cnt_q;
    ack_d    = '0;
    hit_ev   = '0;
    miss_ev  = '0;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    score_d  = score_q;
    misses_d = misses_q;
    nh       = '0;
    nm       = '0;
    win      = BASE_W >> level;
    if (win == '0) win = CW'(1);

    if (state_q == S_PLAY) begin
      for (int i = 0; i < NUM_MOLES; i++) begin
        if (up_q[i]) begin
          if (whack[i]) begin
            up_d[i]   = 1'b0;
            hit_ev[i] = 1'b1;
          end else if (ms_tick) begin
            if (cnt_q[i] == CW'(1)) begin
              up_d[i]    = 1'b0;
              miss_ev[i] = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] - CW'(1);
            end
          end
        end else begin
          if (whack[i]) miss_ev[i] = 1'b1;
          if (spawn[i]) begin
            up_d[i]  = 1'b1;
            cnt_d[i] = win;
            ack_d[i] = 1'b1;
          end
        end
      end
    end

    for (int i = 0; i < NUM_MOLES; i++) begin
      nh = nh + 4'(hit_ev[i]);
      nm = nm + 4'(miss_ev[i]);
    end
    ssum = SWS'(score_q) + SWS'(nh);
    msum = MWS'(misses_q) + MWS'(nm);

    unique case (state_q)
      S_PLAY: begin
        hit_d    = |hit_ev;
        miss_d   = |miss_ev;
        score_d  = (ssum > SWS'(SCORE_MAX)) ? SW'(SCORE_MAX) : SW'(ssum);
        misses_d = MW'(msum);
        if (msum >= MWS'(MISS_LIMIT)) begin
          misses_d = MW'(MISS_LIMIT);
          state_d  = S_OVER;
          up_d     = '0;
          ack_d    = '0;
        end
      end
      default: begin
        up_d = '0;
      end
    endcase

    if (game_start) begin
      state_d  = S_PLAY;
      up_d     = '0;
      ack_d    = '0;
      hit_d    = 1'b0;
      miss_d   = 1'b0;
      score_d  = '0;
      misses_d = '0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      up_q     <= '0;
      ack_q    <= '0;
      cnt_q    <= '{default: '0};
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
      score_q  <= '0;
      misses_q <= '0;
    end else begin
      state_q  <= state_d;
      up_q     <= up_d;
      ack_q    <= ack_d;
      cnt_q    <= cnt_d;
      hit_q    <= hit_d;
      miss_q   <= miss_d;
      score_q  <= score_d;
      misses_q <= misses_d;
    end
  end

  assign spawn_ack  = ack_q;
  assign mole_up    = up_q;
  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign game_over  = (state_q == S_OVER);

endmodule

// File: tb/tb_mole_whack_judge.sv
// Bench for mole_whack_judge: vector table plus hand-written
// sequences, expected values queued at drive time.
module tb_mole_whack_judge;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ms_tick = 1'b0;
  logic        game_start = 1'b0;
  logic [1:0]  level = '0;
  logic [3:0]  spawn = '0;
  logic [3:0]  whack = '0;
  logic [3:0]  spawn_ack, mole_up;
  logic        hit_pulse, miss_pulse;
  logic [13:0] score;
  logic [1:0]  misses;
  logic        game_over;

  mole_whack_judge dut (
    .clk(clk), .reset_n(reset_n), .ms_tick(ms_tick),
    .game_start(game_start), .level(level),
    .spawn(spawn), .whack(whack),
    .spawn_ack(spawn_ack), .mole_up(mole_up),
    .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .score(score), .misses(misses), .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       gs;
    logic [1:0] lv;
    logic       tk;
    logic [3:0] sp;
    logic [3:0] wh;
    logic [3:0] ack;
    logic [3:0] up;
    logic       hit;
    logic       miss;
    int         sc;
    int         mi;
    logic       ov;
  } vec_t;

  vec_t exp_q[$];
  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    logic gs, logic [1:0] lv, logic tk,
    logic [3:0] sp, logic [3:0] wh,
    logic [3:0] ack, logic [3:0] up,
    logic hit, logic miss, int sc, int mi, logic ov);
    vec_t v;
    v.gs = gs; v.lv = lv; v.tk = tk;
    v.sp = sp; v.wh = wh;
    v.ack = ack; v.up = up;
    v.hit = hit; v.miss = miss;
    v.sc = sc; v.mi = mi; v.ov = ov;
    return v;
  endfunction

  function automatic void check(string nm,
    logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      n_bad++;
      $display("FAIL v%0d %s: got %0d expected %0d",
               n_vec, nm, act, exp);
    end
  endfunction

  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    game_start = v.gs;
    level      = v.lv;
    ms_tick    = v.tk;
    spawn      = v.sp;
    whack      = v.wh;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    n_vec++;
    check("spawn_ack", 32'(spawn_ack), 32'(e.ack));
    check("mole_up", 32'(mole_up), 32'(e.up));
    check("hit_pulse", 32'(hit_pulse), 32'(e.hit));
    check("miss_pulse", 32'(miss_pulse), 32'(e.miss));
    check("score", 32'(score), 32'(e.sc));
    check("misses", 32'(misses), 32'(e.mi));
    check("game_over", 32'(game_over), 32'(e.ov));
    game_start = 1'b0;
    ms_tick    = 1'b0;
    spawn      = '0;
    whack      = '0;
  endtask

  initial begin
    int s;

    // reset held: inputs toggle, outputs stay zero
    for (int i = 0; i < 3; i++)
      apply(mk(1'b1, 2'd0, 1'b1, 4'($urandom), 4'($urandom),
               4'h0, 4'h0, 1'b0, 1'b0, 0, 0, 1'b0));
    @(negedge clk);
    reset_n = 1'b1;

    // IDLE ignores lanes; start; first spawn
    tbl.push_back(mk(0, 0, 0, 4'b0100, 4'b0000,
                     4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0000, 4'b0010,
                     4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'b0001, 4'b0001,
                     4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0100, 4'b0000,
                     4'b0100, 4'b0100, 0, 0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);

    // 100 ticks, then hit on lane 2
    for (int t = 0; t < 100; t++)
      apply(mk(0, 0, 1, 4'b0, 4'b0,
               4'b0, 4'b0100, 0, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 4'b0, 4'b0100,
             4'b0, 4'b0, 1, 0, 1, 0, 0));
    apply(mk(0, 0, 0, 4'b0, 4'b0,
             4'b0, 4'b0, 0, 0, 1, 0, 0));

    // level 3 timeout: exactly 200 ticks
    apply(mk(0, 3, 0, 4'b0001, 4'b0,
             4'b0001, 4'b0001, 0, 0, 1, 0, 0));
    for (int t = 1; t <= 200; t++) begin
      if (t == 50)
        apply(mk(0, 0, 0, 4'b0, 4'b0,
                 4'b0, 4'b0001, 0, 0, 1, 0, 0));
      apply(mk(0, 0, 1, 4'b0, 4'b0, 4'b0,
               (t < 200) ? 4'b0001 : 4'b0000,
               0, (t == 200), 1, (t == 200) ? 1 : 0, 0));
    end
    apply(mk(0, 0, 0, 4'b0, 4'b0,
             4'b0, 4'b0, 0, 0, 1, 1, 0));

    // whack on the expiring tick wins
    apply(mk(0, 3, 0, 4'b0010, 4'b0,
             4'b0010, 4'b0010, 0, 0, 1, 1, 0));
    for (int t = 1; t < 200; t++)
      apply(mk(0, 0, 1, 4'b0, 4'b0,
               4'b0, 4'b0010, 0, 0, 1, 1, 0));
    apply(mk(0, 0, 1, 4'b0, 4'b0010,
             4'b0, 4'b0, 1, 0, 2, 1, 0));

    // wrong-lane, busy lane, game over, restart
    tbl.delete();
    tbl.push_back(mk(0, 0, 0, 4'b1000, 4'b1000,
                     4'b1000, 4'b1000, 0, 1, 2, 2, 0));
    tbl.push_back(mk(0, 0, 0, 4'b1000, 4'b0000,
                     4'b0000, 4'b1000, 0, 0, 2, 2, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 4'b1000,
                     4'b0000, 4'b0000, 1, 0, 3, 2, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0100, 4'b0000,
                     4'b0100, 4'b0100, 0, 0, 3, 2, 0));
    tbl.push_back(mk(0, 0, 1, 4'b0000, 4'b0001,
                     4'b0000, 4'b0000, 0, 1, 3, 3, 1));
    tbl.push_back(mk(0, 0, 1, 4'b1111, 4'b1111,
                     4'b0000, 4'b0000, 0, 0, 3, 3, 1));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 4'b0000,
                     4'b0000, 4'b0000, 0, 0, 3, 3, 1));
    tbl.push_back(mk(1, 0, 0, 4'b1111, 4'b1111,
                     4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 4'b0001, 4'b0000,
                     4'b0001, 4'b0001, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 4'b0001,
                     4'b0000, 4'b0000, 0, 0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);

    // fill score to 9996, then 9998, then saturate
    s = 0;
    for (int r = 0; r < 2499; r++) begin
      apply(mk(0, 0, 0, 4'b1111, 4'b0,
               4'b1111, 4'b1111, 0, 0, s, 0, 0));
      s += 4;
      apply(mk(0, 0, 0, 4'b0, 4'b1111,
               4'b0, 4'b0, 1, 0, s, 0, 0));
    end
    apply(mk(0, 0, 0, 4'b1100, 4'b0,
             4'b1100, 4'b1100, 0, 0, 9996, 0, 0));
    apply(mk(0, 0, 0, 4'b0, 4'b1100,
             4'b0, 4'b0, 1, 0, 9998, 0, 0));
    apply(mk(0, 0, 0, 4'b0011, 4'b0,
             4'b0011, 4'b0011, 0, 0, 9998, 0, 0));
    apply(mk(0, 0, 0, 4'b0, 4'b0011,
             4'b0, 4'b0, 1, 0, 9999, 0, 0));
    apply(mk(0, 0, 0, 4'b0, 4'b0,
             4'b0, 4'b0, 0, 0, 9999, 0, 0));
    apply(mk(0, 0, 0, 4'b0001, 4'b0,
             4'b0001, 4'b0001, 0, 0, 9999, 0, 0));

    // asynchronous reset mid-game
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    check("async mole_up", 32'(mole_up), 32'd0);
    check("async score", 32'(score), 32'd0);
    check("async game_over", 32'(game_over), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    apply(mk(0, 0, 0, 4'b0001, 4'b0,
             4'b0, 4'b0, 0, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
